// File: rtl/pe_stream_pkg.sv
// Shared widths and FSM encodings for the PE stream controller and its tx channels.
package pe_stream_pkg;

  localparam int unsigned DefIfW   = 8;
  localparam int unsigned DefWtW   = 8;
  localparam int unsigned DefPsumW = 24;
  localparam int unsigned DefCntW  = 8;

  typedef enum logic [1:0] {
    StIdle,
    StRun,
    StDone
  } top_state_e;

  typedef enum logic [1:0] {
    TxIdle,
    TxFetch,
    TxWait,
    TxSend
  } tx_state_e;

endpackage

// File: rtl/pe_tx_chan.sv
// One buffer-to-PE stream: fetch a word, capture it, then offer it on enable/ready until taken.
module pe_tx_chan
  import pe_stream_pkg::*;
#(
  parameter int unsigned DataW = 8,
  parameter int unsigned CntW  = 8
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             go_i,
  input  logic [CntW-1:0]  n_i,
  output logic             done_o,
  output logic             rd_en_o,
  output logic [CntW-1:0]  rd_addr_o,
  input  logic [DataW-1:0] rd_data_i,
  output logic [DataW-1:0] noc_o,
  output logic             enable_o,
  input  logic             ready_i
);

  tx_state_e        state_q, state_d;
  logic [CntW-1:0]  cnt_q, cnt_d;
  logic [CntW-1:0]  n_q, n_d;
  logic [DataW-1:0] hold_q, hold_d;
  logic [CntW-1:0]  cnt_inc;

  assign cnt_inc = cnt_q + CntW'(1);
  // Idle is only reachable mid-run once every word has been handed over.
  assign done_o  = (state_q == TxIdle);

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    n_d       = n_q;
    hold_d    = hold_q;
    rd_en_o   = 1'b0;
    rd_addr_o = '0;
    enable_o  = 1'b0;
    noc_o     = '0;
    unique case (state_q)
      TxIdle: begin
        if (go_i) begin
          cnt_d  = '0;
          n_d    = n_i;
          hold_d = '0;
          if (n_i != '0) state_d = TxFetch;
        end
      end
      TxFetch: begin
        rd_en_o   = 1'b1;
        rd_addr_o = cnt_q;
        state_d   = TxWait;
      end
      TxWait: begin
        hold_d  = rd_data_i;
        state_d = TxSend;
      end
      TxSend: begin
        enable_o = 1'b1;
        noc_o    = hold_q;
        if (ready_i) begin
          cnt_d   = cnt_inc;
          state_d = (cnt_inc < n_q) ? TxFetch : TxIdle;
        end
      end
      default: state_d = TxIdle;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q <= TxIdle;
      cnt_q   <= '0;
      n_q     <= '0;
      hold_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      n_q     <= n_d;
      hold_q  <= hold_d;
    end
  end

endmodule

// File: rtl/pe_stream_ctrl.sv
// Buffer-side PE controller: streams ifmap/weight/ipsum into the PE and writes opsum back.
module pe_stream_ctrl
  import pe_stream_pkg::*;
#(
  parameter int unsigned IfW   = DefIfW,
  parameter int unsigned WtW   = DefWtW,
  parameter int unsigned PsumW = DefPsumW,
  parameter int unsigned CntW  = DefCntW
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             start_i,
  input  logic [CntW-1:0]  n_ifmap_i,
  input  logic [CntW-1:0]  n_weight_i,
  input  logic [CntW-1:0]  n_ipsum_i,
  input  logic [CntW-1:0]  n_opsum_i,
  output logic             if_rd_en_o,
  output logic [CntW-1:0]  if_rd_addr_o,
  input  logic [IfW-1:0]   if_rd_data_i,
  output logic             wt_rd_en_o,
  output logic [CntW-1:0]  wt_rd_addr_o,
  input  logic [WtW-1:0]   wt_rd_data_i,
  output logic             ps_rd_en_o,
  output logic [CntW-1:0]  ps_rd_addr_o,
  input  logic [PsumW-1:0] ps_rd_data_i,
  output logic [IfW-1:0]   ifmap_noc_o,
  output logic             ifmap_enable_o,
  input  logic             ifmap_ready_i,
  output logic [WtW-1:0]   weight_noc_o,
  output logic             weight_enable_o,
  input  logic             weight_ready_i,
  output logic [PsumW-1:0] ipsum_noc_o,
  output logic             ipsum_enable_o,
  input  logic             ipsum_ready_i,
  input  logic [PsumW-1:0] opsum_noc_i,
  input  logic             opsum_enable_i,
  output logic             opsum_ready_o,
  output logic             op_wr_en_o,
  output logic [CntW-1:0]  op_wr_addr_o,
  output logic [PsumW-1:0] op_wr_data_o,
  output logic             busy_o,
  output logic             done_o
);

  top_state_e       state_q, state_d;
  logic [CntW-1:0]  n_op_q, n_op_d;
  logic [CntW-1:0]  rcnt_q, rcnt_d;
  logic             wr_en_q, wr_en_d;
  logic [CntW-1:0]  wr_addr_q, wr_addr_d;
  logic [PsumW-1:0] wr_data_q, wr_data_d;
  logic             go, if_done, wt_done, ps_done, rx_done;

  assign go            = start_i && (state_q == StIdle);
  assign rx_done       = (rcnt_q == n_op_q);
  assign opsum_ready_o = (state_q == StRun) && (rcnt_q < n_op_q);
  assign busy_o        = (state_q == StRun);
  assign done_o        = (state_q == StDone);
  assign op_wr_en_o    = wr_en_q;
  assign op_wr_addr_o  = wr_addr_q;
  assign op_wr_data_o  = wr_data_q;

  pe_tx_chan #(.DataW(IfW), .CntW(CntW)) u_if_chan (
    .clk_i     (clk_i),
    .rst_ni    (rst_ni),
    .go_i      (go),
    .n_i       (n_ifmap_i),
    .done_o    (if_done),
    .rd_en_o   (if_rd_en_o),
    .rd_addr_o (if_rd_addr_o),
    .rd_data_i (if_rd_data_i),
    .noc_o     (ifmap_noc_o),
    .enable_o  (ifmap_enable_o),
    .ready_i   (ifmap_ready_i)
  );

  pe_tx_chan #(.DataW(WtW), .CntW(CntW)) u_wt_chan (
    .clk_i     (clk_i),
    .rst_ni    (rst_ni),
    .go_i      (go),
    .n_i       (n_weight_i),
    .done_o    (wt_done),
    .rd_en_o   (wt_rd_en_o),
    .rd_addr_o (wt_rd_addr_o),
    .rd_data_i (wt_rd_data_i),
    .noc_o     (weight_noc_o),
    .enable_o  (weight_enable_o),
    .ready_i   (weight_ready_i)
  );

  pe_tx_chan #(.DataW(PsumW), .CntW(CntW)) u_ps_chan (
    .clk_i     (clk_i),
    .rst_ni    (rst_ni),
    .go_i      (go),
    .n_i       (n_ipsum_i),
    .done_o    (ps_done),
    .rd_en_o   (ps_rd_en_o),
    .rd_addr_o (ps_rd_addr_o),
    .rd_data_i (ps_rd_data_i),
    .noc_o     (ipsum_noc_o),
    .enable_o  (ipsum_enable_o),
    .ready_i   (ipsum_ready_i)
  );

  always_comb begin
    state_d   = state_q;
    n_op_d    = n_op_q;
    rcnt_d    = rcnt_q;
    wr_en_d   = 1'b0;
    wr_addr_d = '0;
    wr_data_d = '0;
    unique case (state_q)
      StIdle: begin
        if (start_i) begin
          state_d = StRun;
          n_op_d  = n_opsum_i;
          rcnt_d  = '0;
        end
      end
      StRun: begin
        if (opsum_enable_i && opsum_ready_o) begin
          wr_en_d   = 1'b1;
          wr_addr_d = rcnt_q;
          wr_data_d = opsum_noc_i;
          rcnt_d    = rcnt_q + CntW'(1);
        end
        // rx_done is first true in the cycle the final write is on the port.
        if (if_done && wt_done && ps_done && rx_done) state_d = StDone;
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q   <= StIdle;
      n_op_q    <= '0;
      rcnt_q    <= '0;
      wr_en_q   <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
    end else begin
      state_q   <= state_d;
      n_op_q    <= n_op_d;
      rcnt_q    <= rcnt_d;
      wr_en_q   <= wr_en_d;
      wr_addr_q <= wr_addr_d;
      wr_data_q <= wr_data_d;
    end
  end

endmodule

// File: tb/tb_pe_stream_ctrl.sv
// Randomized bench for pe_stream_ctrl against a transaction-level model of the channels.
module tb_pe_stream_ctrl;

  localparam int unsigned IfW   = 8;
  localparam int unsigned WtW   = 8;
  localparam int unsigned PsumW = 24;
  localparam int unsigned CntW  = 8;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic start = 1'b0;
  logic [CntW-1:0]  n_ifmap = '0, n_weight = '0, n_ipsum = '0, n_opsum = '0;
  logic             if_rd_en, wt_rd_en, ps_rd_en;
  logic [CntW-1:0]  if_rd_addr, wt_rd_addr, ps_rd_addr;
  logic [IfW-1:0]   if_rd_data = '0;
  logic [WtW-1:0]   wt_rd_data = '0;
  logic [PsumW-1:0] ps_rd_data = '0;
  logic [IfW-1:0]   ifmap_noc;
  logic [WtW-1:0]   weight_noc;
  logic [PsumW-1:0] ipsum_noc;
  logic             ifmap_enable, weight_enable, ipsum_enable;
  logic             ifmap_ready = 1'b0, weight_ready = 1'b0, ipsum_ready = 1'b0;
  logic [PsumW-1:0] opsum_noc = '0;
  logic             opsum_enable = 1'b0;
  logic             opsum_ready;
  logic             op_wr_en;
  logic [CntW-1:0]  op_wr_addr;
  logic [PsumW-1:0] op_wr_data;
  logic             busy, done;

  always #5 clk = ~clk;

  pe_stream_ctrl #(.IfW(IfW), .WtW(WtW), .PsumW(PsumW), .CntW(CntW)) dut (
    .clk_i          (clk),
    .rst_ni         (rst_n),
    .start_i        (start),
    .n_ifmap_i      (n_ifmap),
    .n_weight_i     (n_weight),
    .n_ipsum_i      (n_ipsum),
    .n_opsum_i      (n_opsum),
    .if_rd_en_o     (if_rd_en),
    .if_rd_addr_o   (if_rd_addr),
    .if_rd_data_i   (if_rd_data),
    .wt_rd_en_o     (wt_rd_en),
    .wt_rd_addr_o   (wt_rd_addr),
    .wt_rd_data_i   (wt_rd_data),
    .ps_rd_en_o     (ps_rd_en),
    .ps_rd_addr_o   (ps_rd_addr),
    .ps_rd_data_i   (ps_rd_data),
    .ifmap_noc_o    (ifmap_noc),
    .ifmap_enable_o (ifmap_enable),
    .ifmap_ready_i  (ifmap_ready),
    .weight_noc_o   (weight_noc),
    .weight_enable_o(weight_enable),
    .weight_ready_i (weight_ready),
    .ipsum_noc_o    (ipsum_noc),
    .ipsum_enable_o (ipsum_enable),
    .ipsum_ready_i  (ipsum_ready),
    .opsum_noc_i    (opsum_noc),
    .opsum_enable_i (opsum_enable),
    .opsum_ready_o  (opsum_ready),
    .op_wr_en_o     (op_wr_en),
    .op_wr_addr_o   (op_wr_addr),
    .op_wr_data_o   (op_wr_data),
    .busy_o         (busy),
    .done_o         (done)
  );

  // Model state: per tx channel (0 ifmap, 1 weight, 2 ipsum) and the opsum side.
  logic [31:0] mem [3][256];
  int unsigned ch_n [3];
  int unsigned rd_idx [3];
  int unsigned hs_idx [3];
  int          pct [3];
  int          hold_low [3];
  logic        pend_v [3];
  logic [7:0]  pend_a [3];
  logic        prev_stall [3];
  logic [31:0] prev_noc [3];
  int unsigned n_op, racc, wr_idx, pe_idx;
  int          op_vals [$];
  logic [31:0] acc_q [$];
  int          op_pct;
  logic        run_m, run_pend, rx_hs_prev, stall_arm, stall_done;
  int          cyc, last_evt;
  int          n_checks, n_pass;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] want);
    n_checks++;
    if (obs === want) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", tag, obs, want, cyc);
  endtask

  task automatic clear_model();
    run_m = 1'b0; run_pend = 1'b0; rx_hs_prev = 1'b0;
    for (int c = 0; c < 3; c++) begin
      pend_v[c] = 1'b0; prev_stall[c] = 1'b0; hold_low[c] = 0;
    end
  endtask

  task automatic do_reset(input int ncyc, input logic with_start);
    @(negedge clk);
    rst_n = 1'b0; start = with_start;
    ifmap_ready = 1'b1; weight_ready = 1'b1; ipsum_ready = 1'b1;
    opsum_enable = 1'b1; opsum_noc = '1;
    repeat (ncyc) @(negedge clk);
    check_eq("rst_rd_en", 32'({if_rd_en, wt_rd_en, ps_rd_en}), 0);
    check_eq("rst_rd_addr", 32'({if_rd_addr, wt_rd_addr, ps_rd_addr}), 0);
    check_eq("rst_enable", 32'({ifmap_enable, weight_enable, ipsum_enable}), 0);
    check_eq("rst_noc_iw", 32'({ifmap_noc, weight_noc}), 0);
    check_eq("rst_noc_ps", 32'(ipsum_noc), 0);
    check_eq("rst_opsum_ready", 32'(opsum_ready), 0);
    check_eq("rst_wr", 32'({op_wr_en, op_wr_addr}), 0);
    check_eq("rst_wr_data", 32'(op_wr_data), 0);
    check_eq("rst_busy_done", 32'({busy, done}), 0);
    rst_n = 1'b1; start = 1'b0;
    ifmap_ready = 1'b0; weight_ready = 1'b0; ipsum_ready = 1'b0;
    opsum_enable = 1'b0;
    clear_model();
  endtask

  task automatic step(input logic do_start);
    logic        en [3];
    logic        rde [3];
    logic        rdy [3];
    logic [31:0] noc [3];
    logic [31:0] adr [3];
    logic        exp_done, complete, rx_hs;
    @(negedge clk);
    cyc++;
    if (run_pend) begin run_m = 1'b1; run_pend = 1'b0; end
    // Read data is only meaningful the cycle after the strobe; garbage otherwise.
    if_rd_data = pend_v[0] ? mem[0][pend_a[0]][IfW-1:0]   : IfW'($urandom);
    wt_rd_data = pend_v[1] ? mem[1][pend_a[1]][WtW-1:0]   : WtW'($urandom);
    ps_rd_data = pend_v[2] ? mem[2][pend_a[2]][PsumW-1:0] : PsumW'($urandom);
    en[0] = ifmap_enable; en[1] = weight_enable; en[2] = ipsum_enable;
    rde[0] = if_rd_en; rde[1] = wt_rd_en; rde[2] = ps_rd_en;
    noc[0] = 32'(ifmap_noc); noc[1] = 32'(weight_noc); noc[2] = 32'(ipsum_noc);
    adr[0] = 32'(if_rd_addr); adr[1] = 32'(wt_rd_addr); adr[2] = 32'(ps_rd_addr);

    complete = (racc == n_op);
    for (int c = 0; c < 3; c++) if (hs_idx[c] != ch_n[c]) complete = 1'b0;
    exp_done = run_m && complete && (cyc == last_evt + 2);
    check_eq("done", 32'(done), 32'(exp_done));
    if (exp_done) run_m = 1'b0;
    check_eq("busy", 32'(busy), 32'(run_m));
    check_eq("opsum_ready", 32'(opsum_ready), 32'(run_m && (racc < n_op)));

    start = do_start;
    if (do_start && !run_m && !run_pend && !exp_done) begin
      run_pend = 1'b1; last_evt = cyc;
      racc = 0; wr_idx = 0; stall_done = 1'b0;
      acc_q.delete();
      for (int c = 0; c < 3; c++) begin rd_idx[c] = 0; hs_idx[c] = 0; end
    end

    if (stall_arm && weight_enable && weight_noc == 8'hFE && !stall_done) begin
      hold_low[1] = 5; stall_done = 1'b1;
    end
    for (int c = 0; c < 3; c++) begin
      if (hold_low[c] > 0) begin rdy[c] = 1'b0; hold_low[c]--; end
      else rdy[c] = (int'($urandom_range(99)) < pct[c]);
    end
    ifmap_ready = rdy[0]; weight_ready = rdy[1]; ipsum_ready = rdy[2];

    for (int c = 0; c < 3; c++) begin
      if (prev_stall[c]) begin
        check_eq($sformatf("stall_enable%0d", c), 32'(en[c]), 1);
        check_eq($sformatf("stall_noc%0d", c), noc[c], prev_noc[c]);
      end
      if (!en[c]) check_eq($sformatf("idle_noc%0d", c), noc[c], 0);
      else check_eq($sformatf("en_pending%0d", c), 32'(hs_idx[c] < ch_n[c]), 1);
      if (rde[c]) begin
        check_eq($sformatf("rd_in_range%0d", c), 32'(rd_idx[c] < ch_n[c]), 1);
        check_eq($sformatf("rd_addr%0d", c), adr[c], rd_idx[c]);
        rd_idx[c]++;
      end
      pend_v[c] = rde[c];
      pend_a[c] = adr[c][7:0];
      if (en[c] && rdy[c]) begin
        check_eq($sformatf("hs_in_range%0d", c), 32'(hs_idx[c] < ch_n[c]), 1);
        check_eq($sformatf("hs_data%0d", c), noc[c], mem[c][hs_idx[c][7:0]]);
        hs_idx[c]++;
        last_evt = cyc;
      end
      prev_stall[c] = en[c] && !rdy[c];
      prev_noc[c]   = noc[c];
    end

    check_eq("wr_en", 32'(op_wr_en), 32'(rx_hs_prev));
    if (op_wr_en) begin
      check_eq("wr_addr", 32'(op_wr_addr), wr_idx);
      check_eq("wr_data", 32'(op_wr_data),
               (wr_idx < acc_q.size()) ? acc_q[wr_idx] : 32'hDEAD_BEEF);
      wr_idx++;
    end
    // PE opsum side: hold the word until accepted, then idle for a random gap.
    if (rx_hs_prev) begin opsum_enable = 1'b0; opsum_noc = PsumW'($urandom); pe_idx++; end
    if (!opsum_enable && pe_idx < op_vals.size() && int'($urandom_range(99)) < op_pct) begin
      opsum_enable = 1'b1;
      opsum_noc    = op_vals[pe_idx][PsumW-1:0];
    end
    rx_hs = opsum_enable && opsum_ready;
    if (rx_hs) begin
      acc_q.push_back(32'(op_vals[pe_idx][PsumW-1:0]));
      racc++;
      last_evt = cyc;
    end
    rx_hs_prev = rx_hs;
  endtask

  task automatic run_test(input int n0, input int n1, input int n2, input int n3,
                          input int abort_at);
    int budget;
    ch_n[0] = n0; ch_n[1] = n1; ch_n[2] = n2; n_op = n3;
    n_ifmap = CntW'(n0); n_weight = CntW'(n1); n_ipsum = CntW'(n2); n_opsum = CntW'(n3);
    opsum_enable = 1'b0; pe_idx = 0;
    step(1'b1);
    budget = 4000;
    while ((run_m || run_pend) && budget > 0) begin
      if (abort_at > 0 && hs_idx[0] >= abort_at) break;
      // A start pulse mid-run must be ignored.
      step(budget == 3990);
      budget--;
    end
    if (abort_at == 0) begin
      check_eq("finished", 32'(budget > 0), 1);
      for (int c = 0; c < 3; c++) check_eq($sformatf("hs_count%0d", c), hs_idx[c], ch_n[c]);
      check_eq("wr_count", wr_idx, n_op);
      step(1'b0);
    end
  endtask

  initial begin
    n_checks = 0; n_pass = 0; cyc = 0; last_evt = 0;
    n_op = 0; racc = 0; wr_idx = 0; pe_idx = 0; op_pct = 50;
    stall_arm = 1'b0; stall_done = 1'b0;
    for (int c = 0; c < 3; c++) begin ch_n[c] = 0; rd_idx[c] = 0; hs_idx[c] = 0; pct[c] = 100; end
    for (int i = 0; i < 256; i++) begin
      mem[0][i] = 32'((i * 7 + 3) % 256);
      mem[1][i] = 32'((240 + i) % 256);
      mem[2][i] = 32'((24'h5A0000 + i * 1031) % 24'hFFFFFF);
    end
    clear_model();

    do_reset(2, 1'b1);
    repeat (2) step(1'b0);

    // Ready tied high, no stall.
    run_test(24, 18, 8, 0, 0);

    // Weight word 0xFE (index 14) sees ready held low for 5 cycles.
    stall_arm = 1'b1;
    run_test(24, 18, 8, 0, 0);
    check_eq("stall_seen", 32'(stall_done), 1);
    stall_arm = 1'b0;

    op_vals = '{2, -22, 19, 18, -20, -18, 4, 41};
    op_pct = 35;
    run_test(0, 0, 0, 8, 0);

    op_vals.delete();
    run_test(0, 0, 0, 0, 0);

    pct[0] = 70;
    run_test(20, 0, 0, 0, 5);
    do_reset(1, 1'b0);
    step(1'b0);
    run_test(3, 0, 0, 0, 0);

    for (int it = 0; it < 8; it++) begin
      int n3;
      n3 = $urandom_range(12);
      for (int c = 0; c < 3; c++) pct[c] = $urandom_range(100, 20);
      for (int i = 0; i < 256; i++) mem[2][i] = 32'(PsumW'($urandom));
      op_pct = $urandom_range(100, 20);
      op_vals.delete();
      for (int i = 0; i < n3 + 2; i++) op_vals.push_back(int'($urandom));
      run_test($urandom_range(12), $urandom_range(12), $urandom_range(12), n3, 0);
      repeat ($urandom_range(3)) step(1'b0);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
